imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares one synchronous single-port memory between the CPU fetch port (IF, read-only)
//  and the load/store port (DM, read/write). Grants one transaction at a time, tracks
//  the fixed memory latency, and returns read data/acks to the owner. Sits between the
//  core and the instruction/data memory array.
// PARAMETERS
//  AW       32  address width; word address, passed to memory unmodified
//  DW       32  data width
//  MEM_LAT  1   memory read latency in cycles, legal 1..4
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  if_req     in   1   fetch request; hold with if_addr until if_gnt
//  if_addr    in   AW  fetch word address
//  if_gnt     out  1   fetch accepted this cycle (combinational)
//  if_rvalid  out  1   one-cycle pulse, if_rdata valid
//  if_rdata   out  DW  fetched instruction
//  dm_req     in   1   data request; hold with dm_we/addr/wdata until dm_gnt
//  dm_we      in   1   1 = write, 0 = read
//  dm_addr    in   AW  data word address
//  dm_wdata   in   DW  write data
//  dm_gnt     out  1   data request accepted this cycle (combinational)
//  dm_rvalid  out  1   one-cycle pulse: read data valid, or write ack
//  dm_rdata   out  DW  read data; 0 on write ack
//  mem_en     out  1   memory access strobe, high only in grant cycle
//  mem_we     out  1   memory write enable, = dm_we of granted DM write
//  mem_addr   out  AW  granted address
//  mem_wdata  out  DW  granted write data
//  mem_rdata  in   DW  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset: state IDLE, cnt 0, owner none, rr pointer = IF; all outputs 0.
//  - States: IDLE, WAIT. cnt holds remaining latency cycles; owner in {IF, DM}.
//  - Grant window: state IDLE, or WAIT with cnt==1. Outside it if_gnt=dm_gnt=0.
//  - In grant window with any req: assert exactly one gnt, mem_en=1, drive mem_* from
//    winner, latch owner and op, cnt<=MEM_LAT, next state WAIT. No req: next IDLE.
//  - WAIT: cnt decrements each cycle. At cnt==1 pulse <owner>_rvalid with
//    <owner>_rdata=mem_rdata (reads) or 0 (DM write ack); rdata outputs 0 otherwise.
//  - Back-to-back: new grant allowed in the same cycle as the previous rvalid, giving
//    one transaction per MEM_LAT cycles; MEM_LAT=1 sustains one per cycle.
//  - Latency: request granted at cycle T -> rvalid at T+MEM_LAT.
//  - Write timing: mem_we=1 only in grant cycle; memory write occurs on that edge.
//  - Simultaneous if_req and dm_req: arbitration per CONFIGURATION; loser keeps req
//    high and wins at a later grant window (no drop, no duplicate).
//  - Dropping req before gnt is legal; nothing issued. Req after gnt = new transaction.
//  - Reset mid-WAIT: outstanding transaction discarded, no rvalid after rst_n rises.
//  - Addresses wrap naturally at AW bits; no alignment check.
// CONFIGURATION
//  ARB_RR_EN defined: round-robin. On conflict, grant the port not granted last;
//    rr pointer updates on every grant. No conflict: requesting port wins.
//  ARB_RR_EN undefined: fixed priority, DM over IF (older pipeline stage first);
//    IF may starve under continuous DM traffic; rr pointer logic absent.
// TESTING
//  1 Reset: rst_n=0 with if_req=dm_req=1 -> all outputs 0; after release IDLE.
//  2 IF read, MEM_LAT=1, mem[1]=32'h20140001: if_req addr 1 -> if_gnt, mem_en,
//    mem_addr=1 same cycle; if_rvalid, if_rdata=32'h20140001 next cycle.
//  3 Conflict, fixed priority: if_req addr 2 + dm_req read addr 4 same cycle ->
//    dm_gnt first, if_gnt in dm_rvalid cycle; each rvalid once with correct data.
//  4 ARB_RR_EN, both reqs held 6 grants -> grants alternate DM,IF,DM,IF,... (starting
//    with the port not last granted); no port granted twice in a row.
//  5 DM write, MEM_LAT=2: addr 16 wdata 32'h2D -> mem_we=1 grant cycle only;
//    dm_rvalid at T+2, dm_rdata=0; subsequent read of 16 returns 32'h2D.
//  6 MEM_LAT=3: IF granted, rst_n pulsed low at T+1 -> no if_rvalid at T+3;
//    re-issued read after reset completes normally.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and shared memory bus around imem_port_arbiter.
// slave: arbiter side; master: core + memory side.
interface imem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch (IF) and load/store (DM) ports.
// ARB_RR_EN defined: round-robin on conflict; undefined: fixed priority, DM over IF.
module imem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  imem_port_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT     = 1'b1;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;
  localparam logic [2:0] LAT      = 3'(MEM_LAT);

  logic [0:0]    state;
  logic [2:0]    cnt;
  logic [1:0]    owner;
  logic          op_we;

  logic          last_cycle;
  logic          window;
  logic          dm_win;
  logic          if_gnt;
  logic          dm_gnt;
  logic          any_gnt;
  logic          mem_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          if_rvalid;
  logic          dm_rvalid;
  logic [DW-1:0] if_rdata;
  logic [DW-1:0] dm_rdata;

  // The response cycle doubles as the next grant window, giving one transaction per MEM_LAT cycles.
  assign last_cycle = (state == WAIT) && (cnt == 3'd1);
  assign window     = rst_n && ((state == IDLE) || last_cycle);

`ifdef ARB_RR_EN
  logic rr_last;  // 1: DM was granted last, 0: IF

  assign dm_win = bus.dm_req && (!bus.if_req || !rr_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b0;
    end else if (any_gnt) begin
      rr_last <= dm_gnt;
    end
  end
`else
  assign dm_win = bus.dm_req;
`endif

  always_comb begin
    dm_gnt    = window && dm_win;
    if_gnt    = window && bus.if_req && !dm_win;
    any_gnt   = dm_gnt || if_gnt;
    mem_we    = dm_gnt && bus.dm_we;
    sel_addr  = '0;
    sel_wdata = '0;
    if (dm_gnt) begin
      sel_addr  = bus.dm_addr;
      sel_wdata = bus.dm_we ? bus.dm_wdata : '0;
    end else if (if_gnt) begin
      sel_addr  = bus.if_addr;
    end
  end

  always_comb begin
    if_rvalid = last_cycle && (owner == OWN_IF);
    dm_rvalid = last_cycle && (owner == OWN_DM);
    if_rdata  = if_rvalid ? bus.mem_rdata : '0;
    dm_rdata  = (dm_rvalid && !op_we) ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= OWN_NONE;
      op_we <= 1'b0;
    end else if (any_gnt) begin
      state <= WAIT;
      cnt   <= LAT;
      owner <= dm_gnt ? OWN_DM : OWN_IF;
      op_we <= mem_we;
    end else if (state == WAIT) begin
      if (cnt == 3'd1) begin
        state <= IDLE;
        cnt   <= '0;
        owner <= OWN_NONE;
        op_we <= 1'b0;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rvalid = if_rvalid;
  assign bus.dm_rvalid = dm_rvalid;
  assign bus.if_rdata  = if_rdata;
  assign bus.dm_rdata  = dm_rdata;
  assign bus.mem_en    = any_gnt;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: three lanes with MEM_LAT = 1, 2, 3, each with its own memory model.
module tb_imem_port_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    imem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    imem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(g + 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );

    // Memory preset to 0x20140000 + address; read data appears MEM_LAT cycles after mem_en.
    logic [31:0] mem  [0:63];
    logic [31:0] pipe [0:2];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h2014_0000 + 32'(i);
    always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
      pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[5:0]] : 32'hDEAD_BEEF;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign bus.mem_rdata = pipe[g];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    g_lane[0].bus.if_req = 0; g_lane[0].bus.if_addr = '0; g_lane[0].bus.dm_req = 0;
    g_lane[0].bus.dm_we  = 0; g_lane[0].bus.dm_addr = '0; g_lane[0].bus.dm_wdata = '0;
    g_lane[1].bus.if_req = 0; g_lane[1].bus.if_addr = '0; g_lane[1].bus.dm_req = 0;
    g_lane[1].bus.dm_we  = 0; g_lane[1].bus.dm_addr = '0; g_lane[1].bus.dm_wdata = '0;
    g_lane[2].bus.if_req = 0; g_lane[2].bus.if_addr = '0; g_lane[2].bus.dm_req = 0;
    g_lane[2].bus.dm_we  = 0; g_lane[2].bus.dm_addr = '0; g_lane[2].bus.dm_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    g_lane[0].bus.if_req = 1; g_lane[0].bus.if_addr = 32'd9;
    g_lane[0].bus.dm_req = 1; g_lane[0].bus.dm_we = 1; g_lane[0].bus.dm_addr = 32'd9;
    g_lane[0].bus.dm_wdata = 32'h5;
    @(negedge clk);
    vectors++;
    if ({g_lane[0].bus.if_gnt, g_lane[0].bus.dm_gnt, g_lane[0].bus.mem_en, g_lane[0].bus.mem_we} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got gnt/en/we=%b want 0000",
               {g_lane[0].bus.if_gnt, g_lane[0].bus.dm_gnt, g_lane[0].bus.mem_en, g_lane[0].bus.mem_we});
    end
    vectors++;
    if ({g_lane[0].bus.mem_addr, g_lane[0].bus.mem_wdata} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0", g_lane[0].bus.mem_addr, g_lane[0].bus.mem_wdata);
    end
    vectors++;
    if ({g_lane[0].bus.if_rvalid, g_lane[0].bus.dm_rvalid, g_lane[0].bus.if_rdata, g_lane[0].bus.dm_rdata} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_resp: got rvalid=%b%b if_rdata=%h dm_rdata=%h want 0",
               g_lane[0].bus.if_rvalid, g_lane[0].bus.dm_rvalid, g_lane[0].bus.if_rdata, g_lane[0].bus.dm_rdata);
    end
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (g_lane[0].bus.mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got mem_en=%b want 0", g_lane[0].bus.mem_en);
    end
    next_cycle();
  endtask

  task automatic test_if_read();
    g_lane[0].bus.if_req = 1; g_lane[0].bus.if_addr = 32'd1;
    @(negedge clk);
    vectors++;
    if ({g_lane[0].bus.if_gnt, g_lane[0].bus.dm_gnt, g_lane[0].bus.mem_en, g_lane[0].bus.mem_we} !== 4'b1010) begin
      miscompares++;
      $display("FAIL if_read_grant: got gnt/en/we=%b want 1010",
               {g_lane[0].bus.if_gnt, g_lane[0].bus.dm_gnt, g_lane[0].bus.mem_en, g_lane[0].bus.mem_we});
    end
    vectors++;
    if (g_lane[0].bus.mem_addr !== 32'd1) begin
      miscompares++;
      $display("FAIL if_read_addr: got %h want 00000001", g_lane[0].bus.mem_addr);
    end
    next_cycle();
    g_lane[0].bus.if_req = 0;
    @(negedge clk);
    vectors++;
    if (g_lane[0].bus.if_rvalid !== 1'b1 || g_lane[0].bus.if_rdata !== 32'h2014_0001) begin
      miscompares++;
      $display("FAIL if_read_data: got rvalid=%b rdata=%h want 1 20140001", g_lane[0].bus.if_rvalid, g_lane[0].bus.if_rdata);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (g_lane[0].bus.if_rvalid !== 1'b0 || g_lane[0].bus.if_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL if_read_after: got rvalid=%b rdata=%h want 0 0", g_lane[0].bus.if_rvalid, g_lane[0].bus.if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_conflict();
    g_lane[0].bus.if_req = 1; g_lane[0].bus.if_addr = 32'd2;
    g_lane[0].bus.dm_req = 1; g_lane[0].bus.dm_we = 0; g_lane[0].bus.dm_addr = 32'd4;
    @(negedge clk);
    vectors++;
    if ({g_lane[0].bus.dm_gnt, g_lane[0].bus.if_gnt} !== 2'b10 || g_lane[0].bus.mem_addr !== 32'd4) begin
      miscompares++;
      $display("FAIL conflict_first: got dm/if gnt=%b%b addr=%h want 10 00000004",
               g_lane[0].bus.dm_gnt, g_lane[0].bus.if_gnt, g_lane[0].bus.mem_addr);
    end
    next_cycle();
    g_lane[0].bus.dm_req = 0;
    @(negedge clk);
    vectors++;
    if (g_lane[0].bus.dm_rvalid !== 1'b1 || g_lane[0].bus.dm_rdata !== 32'h2014_0004) begin
      miscompares++;
      $display("FAIL conflict_dm_data: got rvalid=%b rdata=%h want 1 20140004", g_lane[0].bus.dm_rvalid, g_lane[0].bus.dm_rdata);
    end
    vectors++;
    if (g_lane[0].bus.if_gnt !== 1'b1 || g_lane[0].bus.mem_addr !== 32'd2) begin
      miscompares++;
      $display("FAIL conflict_if_gnt: got if_gnt=%b addr=%h want 1 00000002", g_lane[0].bus.if_gnt, g_lane[0].bus.mem_addr);
    end
    next_cycle();
    g_lane[0].bus.if_req = 0;
    @(negedge clk);
    vectors++;
    if ({g_lane[0].bus.if_rvalid, g_lane[0].bus.dm_rvalid} !== 2'b10 || g_lane[0].bus.if_rdata !== 32'h2014_0002) begin
      miscompares++;
      $display("FAIL conflict_if_data: got if/dm rvalid=%b%b rdata=%h want 10 20140002",
               g_lane[0].bus.if_rvalid, g_lane[0].bus.dm_rvalid, g_lane[0].bus.if_rdata);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({g_lane[0].bus.if_rvalid, g_lane[0].bus.dm_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL conflict_no_dup: got if/dm rvalid=%b%b want 00", g_lane[0].bus.if_rvalid, g_lane[0].bus.dm_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic exp_dm;
    logic prev_dm;
    prev_dm = 1'b0;
    g_lane[0].bus.if_req = 1; g_lane[0].bus.if_addr = 32'd10;
    g_lane[0].bus.dm_req = 1; g_lane[0].bus.dm_we = 0; g_lane[0].bus.dm_addr = 32'd20;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_EN
      exp_dm = ((i % 2) == 0);
`else
      exp_dm = 1'b1;
`endif
      @(negedge clk);
      vectors++;
      if ({g_lane[0].bus.dm_gnt, g_lane[0].bus.if_gnt} !== {exp_dm, !exp_dm}) begin
        miscompares++;
        $display("FAIL b2b_grant[%0d]: got dm/if gnt=%b%b want %b%b", i,
                 g_lane[0].bus.dm_gnt, g_lane[0].bus.if_gnt, exp_dm, !exp_dm);
      end
      if (i > 0) begin
        vectors++;
        if ({g_lane[0].bus.dm_rvalid, g_lane[0].bus.if_rvalid} !== {prev_dm, !prev_dm}) begin
          miscompares++;
          $display("FAIL b2b_rvalid[%0d]: got dm/if rvalid=%b%b want %b%b", i,
                   g_lane[0].bus.dm_rvalid, g_lane[0].bus.if_rvalid, prev_dm, !prev_dm);
        end
      end
      prev_dm = exp_dm;
      next_cycle();
    end
    g_lane[0].bus.dm_req = 0;
    @(negedge clk);
    vectors++;
    if (g_lane[0].bus.if_gnt !== 1'b1 || g_lane[0].bus.dm_rvalid !== prev_dm) begin
      miscompares++;
      $display("FAIL b2b_if_wins: got if_gnt=%b dm_rvalid=%b want 1 %b", g_lane[0].bus.if_gnt, g_lane[0].bus.dm_rvalid, prev_dm);
    end
    next_cycle();
    g_lane[0].bus.if_req = 0;
    @(negedge clk);
    vectors++;
    if (g_lane[0].bus.if_rvalid !== 1'b1 || g_lane[0].bus.if_rdata !== 32'h2014_000A) begin
      miscompares++;
      $display("FAIL b2b_if_data: got rvalid=%b rdata=%h want 1 2014000a", g_lane[0].bus.if_rvalid, g_lane[0].bus.if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_dm_write();
    g_lane[1].bus.dm_req = 1; g_lane[1].bus.dm_we = 1;
    g_lane[1].bus.dm_addr = 32'd16; g_lane[1].bus.dm_wdata = 32'h2D;
    @(negedge clk);
    vectors++;
    if ({g_lane[1].bus.dm_gnt, g_lane[1].bus.mem_en, g_lane[1].bus.mem_we} !== 3'b111 ||
        g_lane[1].bus.mem_addr !== 32'd16 || g_lane[1].bus.mem_wdata !== 32'h2D) begin
      miscompares++;
      $display("FAIL wr_grant: got gnt/en/we=%b addr=%h wdata=%h want 111 00000010 0000002d",
               {g_lane[1].bus.dm_gnt, g_lane[1].bus.mem_en, g_lane[1].bus.mem_we},
               g_lane[1].bus.mem_addr, g_lane[1].bus.mem_wdata);
    end
    next_cycle();
    g_lane[1].bus.dm_req = 0; g_lane[1].bus.dm_we = 0;
    @(negedge clk);
    vectors++;
    if ({g_lane[1].bus.mem_we, g_lane[1].bus.dm_rvalid, g_lane[1].bus.dm_gnt} !== 3'b000) begin
      miscompares++;
      $display("FAIL wr_wait: got we/rvalid/gnt=%b want 000",
               {g_lane[1].bus.mem_we, g_lane[1].bus.dm_rvalid, g_lane[1].bus.dm_gnt});
    end
    next_cycle();
    g_lane[1].bus.dm_req = 1; g_lane[1].bus.dm_we = 0; g_lane[1].bus.dm_addr = 32'd16;
    @(negedge clk);
    vectors++;
    if (g_lane[1].bus.dm_rvalid !== 1'b1 || g_lane[1].bus.dm_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL wr_ack: got rvalid=%b rdata=%h want 1 00000000", g_lane[1].bus.dm_rvalid, g_lane[1].bus.dm_rdata);
    end
    vectors++;
    if (g_lane[1].bus.dm_gnt !== 1'b1 || g_lane[1].bus.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_readback_gnt: got gnt=%b we=%b want 1 0", g_lane[1].bus.dm_gnt, g_lane[1].bus.mem_we);
    end
    next_cycle();
    g_lane[1].bus.dm_req = 0;
    @(negedge clk);
    vectors++;
    if (g_lane[1].bus.dm_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_readback_early: got rvalid=%b want 0", g_lane[1].bus.dm_rvalid);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (g_lane[1].bus.dm_rvalid !== 1'b1 || g_lane[1].bus.dm_rdata !== 32'h2D) begin
      miscompares++;
      $display("FAIL wr_readback_data: got rvalid=%b rdata=%h want 1 0000002d", g_lane[1].bus.dm_rvalid, g_lane[1].bus.dm_rdata);
    end
    next_cycle();
  endtask

  task automatic test_drop_req();
    g_lane[1].bus.dm_req = 1; g_lane[1].bus.dm_we = 0; g_lane[1].bus.dm_addr = 32'd3;
    @(negedge clk);
    next_cycle();
    g_lane[1].bus.dm_req = 0;
    g_lane[1].bus.if_req = 1; g_lane[1].bus.if_addr = 32'd7;
    @(negedge clk);
    vectors++;
    if ({g_lane[1].bus.if_gnt, g_lane[1].bus.mem_en} !== 2'b00) begin
      miscompares++;
      $display("FAIL drop_outside_window: got gnt/en=%b%b want 00", g_lane[1].bus.if_gnt, g_lane[1].bus.mem_en);
    end
    next_cycle();
    g_lane[1].bus.if_req = 0;
    @(negedge clk);
    vectors++;
    if ({g_lane[1].bus.if_gnt, g_lane[1].bus.mem_en, g_lane[1].bus.dm_rvalid} !== 3'b001 ||
        g_lane[1].bus.dm_rdata !== 32'h2014_0003) begin
      miscompares++;
      $display("FAIL drop_dm_data: got gnt/en/rvalid=%b rdata=%h want 001 20140003",
               {g_lane[1].bus.if_gnt, g_lane[1].bus.mem_en, g_lane[1].bus.dm_rvalid}, g_lane[1].bus.dm_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      vectors++;
      if ({g_lane[1].bus.if_rvalid, g_lane[1].bus.dm_rvalid} !== 2'b00) begin
        miscompares++;
        $display("FAIL drop_no_issue[%0d]: got if/dm rvalid=%b%b want 00", i, g_lane[1].bus.if_rvalid, g_lane[1].bus.dm_rvalid);
      end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    g_lane[2].bus.if_req = 1; g_lane[2].bus.if_addr = 32'd5;
    @(negedge clk);
    vectors++;
    if (g_lane[2].bus.if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_wait_gnt: got %b want 1", g_lane[2].bus.if_gnt);
    end
    next_cycle();
    g_lane[2].bus.if_req = 0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (g_lane[2].bus.if_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_wait_discard[%0d]: got if_rvalid=%b want 0", i, g_lane[2].bus.if_rvalid);
      end
      next_cycle();
    end
    g_lane[2].bus.if_req = 1;
    @(negedge clk);
    vectors++;
    if (g_lane[2].bus.if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_reissue_gnt: got %b want 1", g_lane[2].bus.if_gnt);
    end
    next_cycle();
    g_lane[2].bus.if_req = 0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (g_lane[2].bus.if_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_reissue_early[%0d]: got rvalid=%b want 0", i, g_lane[2].bus.if_rvalid);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (g_lane[2].bus.if_rvalid !== 1'b1 || g_lane[2].bus.if_rdata !== 32'h2014_0005) begin
      miscompares++;
      $display("FAIL rst_reissue_data: got rvalid=%b rdata=%h want 1 20140005", g_lane[2].bus.if_rvalid, g_lane[2].bus.if_rdata);
    end
    next_cycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear_inputs();
    #1;
    test_reset();
    test_if_read();
    test_conflict();
    test_back_to_back();
    test_dm_write();
    test_drop_req();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
